// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
//============================================================================
// Module   : fpu_issue_ctrl
// Purpose  : EX-stage issue controller in front of the FPU datapath. Registers
//            the selected FP op and its operands, counts the fixed per-op
//            latency while stalling the pipeline, and captures the FPU result
//            for writeback.
// Options  : FPU_STALL_CNT_EN - adds a saturating stall-cycle counter output
//            (stall_count).
// Revision : 1.0 - initial release
//============================================================================
module fpu_issue_ctrl #(
    parameter int WIDTH    = 32,
    parameter int LAT_ADD  = 7,
    parameter int LAT_MUL  = 5,
    parameter int LAT_DIV  = 6,
    parameter int LAT_SQRT = 16,
    parameter int LAT_CVT  = 6,
    parameter int LAT_CMP  = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             fpu_sel,
    input  logic             flush,
    input  logic [3:0]       fpuOp_in,
    input  logic [2:0]       func3_in,
    input  logic             rs1_0_in,
    input  logic [WIDTH-1:0] dataA_in,
    input  logic [WIDTH-1:0] dataB_in,
    input  logic [WIDTH-1:0] fpuResult,
    output logic [3:0]       fpuOp_q,
    output logic [2:0]       func3_q,
    output logic             rs1_0_q,
    output logic [WIDTH-1:0] dataA_q,
    output logic [WIDTH-1:0] dataB_q,
    output logic             fpu_inprogress,
    output logic             result_valid,
    output logic [WIDTH-1:0] result_q
`ifdef FPU_STALL_CNT_EN
    ,
    output logic [31:0]      stall_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_cnt;
    logic [4:0] w_lat;
    logic       w_accept;
    logic       w_capture;
    logic       w_abort;
    logic       w_inprog;
    logic       w_valid;

    // Latency lookup for the opcode presented by decode; unknown ops finish at once
    always_comb begin
        w_lat = 5'd0;
        case (fpuOp_in)
            4'b0000, 4'b0001: w_lat = 5'(LAT_ADD);
            4'b0010:          w_lat = 5'(LAT_MUL);
            4'b0011:          w_lat = 5'(LAT_DIV);
            4'b0110:          w_lat = 5'(LAT_SQRT);
            4'b1000, 4'b1001: w_lat = 5'(LAT_CVT);
            4'b0101, 4'b0111: w_lat = 5'(LAT_CMP);
            default:          w_lat = 5'd0;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_abort   = 1'b0;
        w_inprog  = 1'b0;
        w_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fpu_sel && !flush) begin
                    w_accept = 1'b1;
                    w_inprog = 1'b1;
                    w_next   = S_EXEC;
                end
            end
            S_EXEC: begin
                w_inprog = 1'b1;
                if (flush) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end else if (r_cnt == 5'd0) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                // EX advances this cycle, so fpu_sel is deliberately ignored
                w_valid = 1'b1;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Stall is gated by clear so every output drops the moment reset is applied
    assign fpu_inprogress = w_inprog & ~clear;
    assign result_valid   = w_valid;

    // Latency counter: loaded at accept, counts down to zero through EXEC
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_cnt <= 5'd0;
        end else if (w_accept) begin
            r_cnt <= w_lat;
        end else if (w_abort) begin
            r_cnt <= 5'd0;
        end else if (r_state == S_EXEC && r_cnt != 5'd0) begin
            r_cnt <= r_cnt - 5'd1;
        end
    end

    // Operand/opcode registers held stable for the FPU from accept until next accept
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            fpuOp_q <= 4'd0;
            func3_q <= 3'd0;
            rs1_0_q <= 1'b0;
            dataA_q <= '0;
            dataB_q <= '0;
        end else if (w_accept) begin
            fpuOp_q <= fpuOp_in;
            func3_q <= func3_in;
            rs1_0_q <= rs1_0_in;
            dataA_q <= dataA_in;
            dataB_q <= dataB_in;
        end
    end

    // Result register: captured on the last EXEC cycle, untouched by a flush
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            result_q <= '0;
        end else if (w_capture) begin
            result_q <= fpuResult;
        end
    end

`ifdef FPU_STALL_CNT_EN
    logic [31:0] r_stall_count;

    // Saturating count of cycles spent stalling the pipeline
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_stall_count <= 32'd0;
        end else if (fpu_inprogress && r_stall_count != 32'hFFFF_FFFF) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire
